// File: rtl/pwm_capture.sv
// pwm_capture: single-channel PWM input capture.
//
// Measures the period (rising edge to rising edge) and high time of an
// asynchronous PWM input in prescaled PCLK ticks. The first rising edge after
// enable, reset or an overflow only arms the block; each later rising edge
// publishes the measurement of the period that just ended.
//
// Ports:
//   PCLK        system clock, all logic on its rising edge
//   PRESETN     synchronous active-low reset
//   PWM_IN      external PWM, asynchronous to PCLK
//   cap_enable  1 = measure, 0 = idle (results and cap_ovf hold)
//   prescale    one tick every prescale+1 PCLK cycles
//   ovf_clr     clears cap_ovf (a simultaneous overflow wins)
//   period_cap  last captured period in ticks
//   high_cap    last captured high time in ticks
//   cap_valid   one-cycle strobe when period_cap/high_cap update
//   cap_ovf     sticky flag: a measurement ran past the counter range
//   pwm_level   synchronized PWM_IN level
module pwm_capture #(
    parameter int APB_DWIDTH = 8
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  PWM_IN,
    input  logic                  cap_enable,
    input  logic [APB_DWIDTH-1:0] prescale,
    input  logic                  ovf_clr,
    output logic [APB_DWIDTH-1:0] period_cap,
    output logic [APB_DWIDTH-1:0] high_cap,
    output logic                  cap_valid,
    output logic                  cap_ovf,
    output logic                  pwm_level
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } state_t;

    state_t                  state;
    logic                    pwm_p0;    // first synchronizer flop
    logic                    pwm_p1;    // second synchronizer flop
    logic                    pwm_p2;    // previous synchronized level
    logic [APB_DWIDTH-1:0]   pre;
    logic [APB_DWIDTH-1:0]   cnt;
    logic [APB_DWIDTH-1:0]   high_lat;
    logic [APB_DWIDTH-1:0]   cnt_next;
    logic [APB_DWIDTH-1:0]   pre_next;
    logic                    tick;
    logic                    rise;
    logic                    fall;
    logic                    ovf_hit;

    // The counter saturates by aborting: a tick arriving while it is already
    // all-ones would wrap, so the measurement is abandoned instead.
    function automatic logic cnt_would_wrap(input logic [APB_DWIDTH-1:0] c,
                                            input logic                  t);
        return (&c) & t;
    endfunction

    always_comb begin
        tick     = (pre == prescale);
        cnt_next = cnt + {{(APB_DWIDTH-1){1'b0}}, tick};
        pre_next = tick ? '0 : pre + 1'b1;
        rise     = pwm_p1 & ~pwm_p2;
        fall     = ~pwm_p1 & pwm_p2;
        ovf_hit  = cnt_would_wrap(cnt, tick);
    end

    assign pwm_level = pwm_p1;

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            pwm_p0     <= 1'b0;
            pwm_p1     <= 1'b0;
            pwm_p2     <= 1'b0;
            pre        <= '0;
            cnt        <= '0;
            high_lat   <= '0;
            period_cap <= '0;
            high_cap   <= '0;
            cap_valid  <= 1'b0;
            cap_ovf    <= 1'b0;
            state      <= IDLE;
        end else begin
            // Stage p0 -> p1 -> p2: two-flop synchronizer plus edge-detect delay
            pwm_p0 <= PWM_IN;
            pwm_p1 <= pwm_p0;
            pwm_p2 <= pwm_p1;

            cap_valid <= 1'b0;
            // Clear first so that an overflow set below in the same cycle wins.
            if (ovf_clr) begin
                cap_ovf <= 1'b0;
            end

            if (!cap_enable) begin
                pre   <= '0;
                cnt   <= '0;
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        pre   <= '0;
                        cnt   <= '0;
                        state <= WAIT_RISE;
                    end
                    WAIT_RISE: begin
                        if (rise) begin
                            pre   <= '0;
                            cnt   <= '0;
                            state <= MEAS_HIGH;
                        end
                    end
                    MEAS_HIGH: begin
                        if (ovf_hit) begin
                            cap_ovf <= 1'b1;
                            state   <= WAIT_RISE;
                        end else begin
                            pre <= pre_next;
                            cnt <= cnt_next;
                            // The count keeps running through the low phase,
                            // so the period is taken from the same counter.
                            if (fall) begin
                                high_lat <= cnt_next;
                                state    <= MEAS_LOW;
                            end
                        end
                    end
                    MEAS_LOW: begin
                        if (ovf_hit) begin
                            cap_ovf <= 1'b1;
                            state   <= WAIT_RISE;
                        end else if (rise) begin
                            period_cap <= cnt_next;
                            high_cap   <= high_lat;
                            cap_valid  <= 1'b1;
                            pre        <= '0;
                            cnt        <= '0;
                            state      <= MEAS_HIGH;
                        end else begin
                            pre <= pre_next;
                            cnt <= cnt_next;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed bench for pwm_capture (APB_DWIDTH = 8).
// Inputs are driven just after the falling edge and outputs are sampled at
// the falling edge, so each sample reflects the preceding rising edge.
module tb_pwm_capture;

    localparam int W = 8;

    logic         PCLK;
    logic         PRESETN;
    logic         PWM_IN;
    logic         cap_enable;
    logic [W-1:0] prescale;
    logic         ovf_clr;
    logic [W-1:0] period_cap;
    logic [W-1:0] high_cap;
    logic         cap_valid;
    logic         cap_ovf;
    logic         pwm_level;

    int n_checks;
    int n_errors;

    pwm_capture #(.APB_DWIDTH(W)) dut (
        .PCLK       (PCLK),
        .PRESETN    (PRESETN),
        .PWM_IN     (PWM_IN),
        .cap_enable (cap_enable),
        .prescale   (prescale),
        .ovf_clr    (ovf_clr),
        .period_cap (period_cap),
        .high_cap   (high_cap),
        .cap_valid  (cap_valid),
        .cap_ovf    (cap_ovf),
        .pwm_level  (pwm_level)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        int pre;
        int n;
        int h;
        int nper;
        int exp_p;
        int exp_h;
        int exp_caps;
        int exp_ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge PCLK);
    endtask

    // Disable, flush the synchronizer, clear the flag, then re-enable.
    task automatic prep(input int pre);
        cap_enable = 1'b0;
        PWM_IN     = 1'b0;
        ovf_clr    = 1'b0;
        repeat (3) step();
        ovf_clr = 1'b1;
        step();
        ovf_clr    = 1'b0;
        prescale   = W'(pre);
        cap_enable = 1'b1;
        step();
    endtask

    // Drive nper periods of n cycles with h cycles high. A capture must land
    // 3 edges after each driven rise (sample slot j == 2), except on the first
    // period when the block is not yet armed.
    task automatic run_pwm(input int n, input int h, input int nper, input bit armed,
                           input int skip, input int exp_caps, input int exp_p, input int exp_h);
        int caps;
        bit ok_slot;
        caps = 0;
        for (int k = 0; k < nper; k++) begin
            for (int j = 0; j < n; j++) begin
                PWM_IN = (j < h);
                step();
                if (cap_valid) begin
                    ok_slot = (j == 2) && (armed || k > 0);
                    check("cap_valid_slot", 32'(ok_slot), 32'd1);
                    caps++;
                    if (caps > skip) begin
                        check("period_cap", 32'(period_cap), 32'(exp_p));
                        check("high_cap", 32'(high_cap), 32'(exp_h));
                    end
                end
            end
        end
        check("cap_count", 32'(caps), 32'(exp_caps));
    endtask

    initial begin
        int nval;
        n_checks   = 0;
        n_errors   = 0;
        PRESETN    = 1'b0;
        PWM_IN     = 1'b0;
        cap_enable = 1'b0;
        prescale   = '0;
        ovf_clr    = 1'b0;

        //              pre  n    h    nper exp_p exp_h caps ovf
        vecs[0] = '{0,   20,  5,   4,   20,   5,    3,   0};
        vecs[1] = '{3,   40,  12,  4,   10,   3,    3,   0};
        vecs[2] = '{0,   10,  3,   3,   10,   3,    2,   0};
        vecs[3] = '{1,   25,  9,   3,   12,   4,    2,   0};
        vecs[4] = '{0,   255, 254, 3,   255,  254,  2,   0};
        vecs[5] = '{0,   256, 128, 3,   0,    0,    0,   1};

        step();

        // Reset with random inputs
        for (int i = 0; i < 6; i++) begin
            PWM_IN     = 1'($urandom);
            cap_enable = 1'($urandom);
            prescale   = W'($urandom);
            ovf_clr    = 1'($urandom);
            step();
        end
        check("rst_period_cap", 32'(period_cap), 32'd0);
        check("rst_high_cap", 32'(high_cap), 32'd0);
        check("rst_cap_valid", 32'(cap_valid), 32'd0);
        check("rst_cap_ovf", 32'(cap_ovf), 32'd0);
        check("rst_pwm_level", 32'(pwm_level), 32'd0);

        // Release with PWM_IN already high: that level arms, the next rise captures
        PRESETN    = 1'b1;
        PWM_IN     = 1'b1;
        cap_enable = 1'b1;
        prescale   = '0;
        ovf_clr    = 1'b0;
        for (int i = 0; i < 30; i++) begin
            PWM_IN = !(i >= 10 && i < 20);
            step();
            if (i == 0)  check("pwm_level_lag0", 32'(pwm_level), 32'd0);
            if (i == 1)  check("pwm_level_lag1", 32'(pwm_level), 32'd1);
            if (i == 10) check("pwm_level_lag10", 32'(pwm_level), 32'd1);
            if (i == 11) check("pwm_level_lag11", 32'(pwm_level), 32'd0);
            check("rel_cap_valid", 32'(cap_valid), (i == 22) ? 32'd1 : 32'd0);
            if (i == 22) begin
                check("rel_period_cap", 32'(period_cap), 32'd20);
                check("rel_high_cap", 32'(high_cap), 32'd10);
            end
        end

        // Table of steady PWM patterns
        for (int v = 0; v < 6; v++) begin
            prep(vecs[v].pre);
            run_pwm(vecs[v].n, vecs[v].h, vecs[v].nper, 1'b0, 0,
                    vecs[v].exp_caps, vecs[v].exp_p, vecs[v].exp_h);
            check("cap_ovf_end", 32'(cap_ovf), 32'(vecs[v].exp_ovf));
        end

        // Duty change at prescale 3: one settling capture, then high = 28/4
        prep(3);
        run_pwm(40, 12, 2, 1'b0, 0, 1, 10, 3);
        run_pwm(40, 28, 3, 1'b1, 1, 3, 10, 7);

        // Overflow: hold high after a rise
        prep(0);
        nval = 0;
        for (int i = 0; i < 300; i++) begin
            PWM_IN = 1'b1;
            step();
            if (cap_valid) nval++;
            if (i == 257) check("ovf_before", 32'(cap_ovf), 32'd0);
            if (i == 258) check("ovf_set", 32'(cap_ovf), 32'd1);
        end
        check("ovf_no_valid", 32'(nval), 32'd0);
        check("ovf_sticky", 32'(cap_ovf), 32'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(cap_ovf), 32'd0);

        // Second overflow with ovf_clr held through it: the set must win
        ovf_clr = 1'b1;
        nval = 0;
        for (int i = 0; i < 5; i++) begin
            PWM_IN = 1'b0;
            step();
            if (cap_valid) nval++;
        end
        for (int i = 0; i < 270; i++) begin
            PWM_IN = 1'b1;
            step();
            if (cap_valid) nval++;
            if (i == 257) check("ovf2_before", 32'(cap_ovf), 32'd0);
            if (i == 258) begin
                check("ovf2_set_vs_clr", 32'(cap_ovf), 32'd1);
                ovf_clr = 1'b0;
            end
        end
        check("ovf2_no_valid", 32'(nval), 32'd0);
        check("ovf2_held", 32'(cap_ovf), 32'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf2_clr", 32'(cap_ovf), 32'd0);

        // Disable during MEAS_LOW: no capture, outputs hold
        prep(0);
        run_pwm(20, 5, 2, 1'b0, 0, 1, 20, 5);
        PWM_IN = 1'b0;
        repeat (3) step();
        cap_enable = 1'b0;
        nval = 0;
        for (int j = 0; j < 20; j++) begin
            PWM_IN = (j < 5);
            step();
            if (cap_valid) nval++;
        end
        check("dis_no_valid", 32'(nval), 32'd0);
        check("dis_period_hold", 32'(period_cap), 32'd20);
        check("dis_high_hold", 32'(high_cap), 32'd5);
        cap_enable = 1'b1;
        step();
        run_pwm(12, 4, 3, 1'b0, 0, 2, 12, 4);

        // Reset pulse mid-MEAS_HIGH
        prep(0);
        run_pwm(20, 5, 2, 1'b0, 0, 1, 20, 5);
        PWM_IN = 1'b1;
        repeat (4) step();
        PRESETN = 1'b0;
        step();
        check("mid_rst_period_cap", 32'(period_cap), 32'd0);
        check("mid_rst_high_cap", 32'(high_cap), 32'd0);
        check("mid_rst_cap_valid", 32'(cap_valid), 32'd0);
        check("mid_rst_cap_ovf", 32'(cap_ovf), 32'd0);
        check("mid_rst_pwm_level", 32'(pwm_level), 32'd0);
        PRESETN = 1'b1;
        PWM_IN  = 1'b0;
        repeat (5) step();
        run_pwm(16, 6, 3, 1'b0, 0, 2, 16, 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Single-channel PWM input capture block: measures the period (rising edge to rising edge) and high time of an external, asynchronous PWM signal in prescaled PCLK ticks. It is the read-side counterpart of the PWM generator and sits beside it on the same APB-clocked peripheral. Its primary use is tachometer and feedback inputs, and loopback checking of generated PWM outputs. Captured values are exposed as register-ready outputs with a one-cycle valid strobe and a sticky overflow flag.

## Interface
- APB_DWIDTH, 8: width of the prescale input, the tick counter and both capture outputs.
- PCLK  in  1  system clock; all logic on its rising edge.
- PRESETN  in  1  reset, synchronous and active-low.
- PWM_IN  in  1  external PWM, asynchronous to PCLK.
- cap_enable  in  1  1 = measure, 0 = idle.
- prescale  in  APB_DWIDTH  tick = every prescale+1 PCLK cycles.
- ovf_clr  in  1  clears cap_ovf.
- period_cap  out  APB_DWIDTH  last captured period, in ticks.
- high_cap  out  APB_DWIDTH  last captured high time, in ticks.
- cap_valid  out  1  one-cycle pulse when period_cap/high_cap update.
- cap_ovf  out  1  sticky timeout/overflow flag.
- pwm_level  out  1  synchronized PWM_IN level (second sync flop).

## Operation
- Input path: sync1 → sync2 → lvl_d.
  - rise = sync2 & ~lvl_d; fall = ~sync2 & lvl_d.
  - Pulses shorter than one PCLK may be missed. This is accepted.
- Prescaler: pre counts 0..prescale. tick = (pre == prescale); on tick, pre ← 0.
  - prescale = 0 gives a tick every cycle.
- cnt_next = cnt + tick.
- State machine:
  - IDLE: pre and cnt held at 0. Go to WAIT_RISE when cap_enable = 1.
  - WAIT_RISE: no counting. On rise: pre ← 0, cnt ← 0, go to MEAS_HIGH. The first rise only arms the block; nothing is captured.
  - MEAS_HIGH: counting. On fall: high_lat ← cnt_next, go to MEAS_LOW. cnt is not cleared.
  - MEAS_LOW: counting. On rise: period_cap ← cnt_next, high_cap ← high_lat, cap_valid ← 1, pre ← 0, cnt ← 0, go to MEAS_HIGH.
- Overflow: in MEAS_HIGH or MEAS_LOW, if cnt is all-ones and tick = 1:
  - cap_ovf ← 1, go to WAIT_RISE.
  - No capture happens; capture outputs hold their values.
  - Maximum measurable value is 2^APB_DWIDTH − 1 ticks.
  - 0% and 100% duty inputs end in overflow, then wait in WAIT_RISE with no further flags.
- Overflow has priority over an edge in the same cycle.
- cap_ovf clears on ovf_clr. If a set and a clear happen in the same cycle, the set wins.
- cap_enable = 0 in any state: go to IDLE next cycle, cap_valid = 0, no capture. period_cap, high_cap and cap_ovf hold.
- Result values:
  - Prescale 0, input period N cycles, high H cycles: period_cap = N, high_cap = H.
  - General prescale p: values = floor(N/(p+1)) and floor(H/(p+1)).
- prescale changes mid-measurement take effect immediately. The measurement in progress is undefined; the next measurement is correct.

## Timing
- Reset (PRESETN = 0 at a PCLK edge) clears everything:
  - Outputs: period_cap, high_cap, cap_valid, cap_ovf, pwm_level all 0.
  - Internal: sync flops, lvl_d, pre, cnt and high_lat all 0.
  - State ← IDLE.
- Reset mid-measurement aborts without a capture. After release, the first rise only re-arms.
- Latency:
  - PWM_IN transition sampled at edge k: sync2 updates at k+1, rise/fall is valid in the cycle after k+1.
  - period_cap, high_cap and cap_valid update at edge k+2.
- cap_valid is high for exactly one PCLK cycle per capture. Back-to-back captures need at least 2 ticks of period.
- pwm_level lags PWM_IN by 2 PCLK edges.
- Enable, disable and ovf_clr take effect at the next PCLK edge.

## Test plan
- Reset: drive random inputs with PRESETN = 0 → all outputs 0. After release with PWM_IN = 1 and cap_enable = 1: no cap_valid until the second rise.
- Prescale 0, PWM period 20, high 5, 4 periods → three cap_valid pulses, each with period_cap = 20, high_cap = 5. Each pulse lands 3 PCLK edges after the PWM_IN rise.
- Prescale 3, period 40, high 12 → period_cap = 10, high_cap = 3. Then change the duty to high 28 → after one settling capture, high_cap = 7.
- APB_DWIDTH = 8, prescale 0, hold PWM_IN high after a rise → cap_ovf = 1 on the 256th tick, no cap_valid, and the state stays WAIT_RISE. Assert ovf_clr on the same cycle as a second overflow → cap_ovf stays 1. ovf_clr alone → 0.
- Drop cap_enable during MEAS_LOW → no cap_valid, outputs hold. Re-enable → first rise discarded, then correct captures.
- Assert PRESETN = 0 for 1 cycle mid-MEAS_HIGH → outputs 0 next edge, then normal capture after re-arm.
